dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MEM stage of the pipelined CPU. Accepts the load/store request carried by the EX/MEM register, holds the pipeline with a stall while a fixed-latency access completes, then presents load data on `Memdata_o` for capture by the MEM/WB register. It is the responding end of the memory interface whose read data feeds the MEM/WB `Memdata` path.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM stage.
// A load/store seen in IDLE is latched, the pipeline is stalled while the
// access counts down, and the access commits on the last BUSY edge so that
// load data is on Memdata_o during the one-cycle DONE pulse.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] Memdata_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wdata;
  logic [31:0]      mem [DEPTH_WORDS];

  logic req;
  logic accept;   // request captured on this edge
  logic fire;     // access performed on this edge

  // Byte offset and address bits above the index are don't-care: accesses
  // are word-aligned and wrap modulo the memory size.
  logic addr_unused;
  assign addr_unused = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  // A simultaneous read and write is treated as a store.
  assign req = MemRead_i | MemWrite_i;

  // Next-state and output decode; reset masks every strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and a latch cannot be inferred.
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    accept     = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          stall_o    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt == '0) begin
          fire       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) begin
      stall_o = 1'b0;
      done_o  = 1'b0;
      accept  = 1'b0;
      fire    = 1'b0;
    end
  end

  // State, latency counter, latched request and registered load data.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      Memdata_o <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt      <= CNT_LOAD;
        op_write <= MemWrite_i;
        idx      <= addr_i[IDX_W+1:2];
        wdata    <= data_i;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire && !op_write) begin
        Memdata_o <= mem[idx];
      end
    end
  end

  // Storage array; the write commits on the final BUSY edge.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset so it maps onto RAM; contents survive
    // reset and a store interrupted by reset never reaches it (fire is 0).
    if (fire && op_write) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a timeline/array reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized load/store phase. A second LATENCY=1 instance covers the
// back-to-back stall pattern.
module tb_dmem_responder;

  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (LATENCY=4)
  logic        rst, rd, wr;
  logic [31:0] addr, wdat;
  logic        stall, done;
  logic [31:0] mdata;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdat),
    .stall_o(stall), .done_o(done), .Memdata_o(mdata)
  );

  // Back-to-back instance (LATENCY=1)
  logic        rst1, rd1, wr1;
  logic [31:0] addr1, wdat1;
  logic        stall1, done1;
  logic [31:0] mdata1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(wdat1),
    .stall_o(stall1), .done_o(done1), .Memdata_o(mdata1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since the request was accepted
  // (-1 = idle). Stall covers the request cycle and L busy cycles; done is
  // the cycle after; the access takes effect at the end of busy cycle L.
  int          age = -1;
  bit          m_wr;
  int          m_idx;
  logic [31:0] m_data;
  logic [31:0] ref_mem [256];
  bit          ref_valid [256];
  logic [31:0] ref_mdata = '0;
  bit          ref_known = 1'b0;

  // Compare DUT against the model mid-cycle, then advance the model across
  // the coming rising edge (inputs are stable from here to that edge).
  always @(negedge clk) begin
    bit exp_stall;
    bit exp_done;
    if (rst) begin
      exp_stall = 1'b0;
      exp_done  = 1'b0;
    end else begin
      exp_stall = (age < 0 && (rd || wr)) || (age >= 1 && age <= L);
      exp_done  = (age == L + 1);
    end
    check("stall", 32'(stall), 32'(exp_stall));
    check("done", 32'(done), 32'(exp_done));
    if (ref_known) check("memdata", mdata, ref_mdata);

    if (rst) begin
      age       = -1;
      ref_mdata = '0;
      ref_known = 1'b1;
    end else if (age < 0) begin
      if (rd || wr) begin
        age    = 1;
        m_wr   = wr;
        m_idx  = int'(addr[9:2]);
        m_data = wdat;
      end
    end else if (age <= L) begin
      if (age == L) begin
        if (m_wr) begin
          ref_mem[m_idx]   = m_data;
          ref_valid[m_idx] = 1'b1;
        end else begin
          ref_mdata = ref_mem[m_idx];
          ref_known = ref_valid[m_idx];
        end
      end
      age++;
    end else begin
      age = -1;
    end
  end

  // Idle for n cycles; called and returns at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One access on the main instance, starting at posedge+1. Returns the
  // number of stall cycles and the Memdata_o value seen in the done cycle.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        output int nstall, output logic [31:0] md);
    bit got_done;
    rd = r; wr = w; addr = a; wdat = d;
    nstall = 0; got_done = 1'b0; md = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (done) begin
        got_done = 1'b1;
        md = mdata;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        addr = $urandom;
        wdat = $urandom;
      end
    end
    check("access_done_seen", 32'(got_done), 32'd1);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int          ns;
    logic [31:0] md;

    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = '0; wdat = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdat1 = '0;

    // Reset held with a pending load request
    repeat (2) begin
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_memdata", mdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b0;

    // LATENCY=1 with a load held continuously: stall 1,1,0 and done every 3
    rst1 = 1'b0; rd1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("b2b_stall", 32'(stall1), 32'(k % 3 != 2));
      check("b2b_done", 32'(done1), 32'(k % 3 == 2));
    end
    @(posedge clk); #1;
    rd1 = 1'b0; rst1 = 1'b1;

    // Store then load with LATENCY=4: five stall cycles each
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, ns, md);
    check("store_stall_cycles", 32'(ns), 32'd5);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, ns, md);
    check("load_stall_cycles", 32'(ns), 32'd5);
    check("load_data", md, 32'hDEADBEEF);

    // Address wrap and ignored byte offset
    access(1'b0, 1'b1, 32'h0000_0404, 32'h12345678, 1'b0, ns, md);
    access(1'b1, 1'b0, 32'h0000_0007, 32'h0, 1'b0, ns, md);
    check("wrap_load", md, 32'h12345678);
    access(1'b1, 1'b0, 32'h0000_0406, 32'h0, 1'b0, ns, md);
    check("align_load", md, 32'h12345678);

    // Simultaneous read and write behaves as a store
    access(1'b0, 1'b1, 32'h40, 32'h11, 1'b0, ns, md);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, ns, md);
    check("pre_rw_load", md, 32'h11);
    access(1'b1, 1'b1, 32'h20, 32'h55, 1'b0, ns, md);
    check("rw_memdata_held", md, 32'h11);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, ns, md);
    check("rw_store_landed", md, 32'h55);

    // Reset in the second BUSY cycle drops the pending store
    access(1'b0, 1'b1, 32'h30, 32'hA5, 1'b0, ns, md);
    idle(1);
    rd = 1'b0; wr = 1'b1; addr = 32'h30; wdat = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_memdata", mdata, 32'd0);
    check("rst_mid_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, ns, md);
    check("rst_mid_store_dropped", md, 32'hA5);

    // Randomized loads/stores with random gaps, upper/lower address noise
    // and input scrambling while busy
    for (int i = 0; i < 150; i++) begin
      int          op;
      int          widx;
      logic [31:0] a;
      bit          scr;
      op   = int'($urandom_range(0, 3));
      widx = int'($urandom_range(0, 15));
      a    = ($urandom & 32'hFFFF_FC03) | 32'(widx << 2);
      scr  = 1'($urandom_range(0, 1));
      access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, $urandom, scr, ns, md);
      check("rand_stall_cycles", 32'(ns), 32'(L + 1));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
